// File: rtl/sc_config_commit.sv
`default_nettype none
// ============================================================================
// Module      : sc_config_commit
// Description : Frame-synchronous commit controller for the scan-converter
//               configuration bank. Staged words are copied to the active
//               outputs in a single cycle, aligned to the next vsync rising
//               edge, on request (immediate), or by a watchdog timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module sc_config_commit #(
    parameter int unsigned NUM_REGS       = 13,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd2000000,
    parameter int unsigned FCNT_W         = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REGS*32-1:0] staged_cfg_i,
    input  logic                   commit_req_i,
    input  logic                   immediate_i,
    input  logic                   vsync_i,
    input  logic                   clr_forced_i,
    output logic [NUM_REGS*32-1:0] active_cfg_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   forced_o,
    output logic [FCNT_W-1:0]      frame_cnt_o
);

    // State encoding
    localparam logic [1:0]  c_st_idle  = 2'd0;
    localparam logic [1:0]  c_st_armed = 2'd1;
    localparam logic [1:0]  c_st_apply = 2'd2;

    // Watchdog terminal count; a zero TIMEOUT_CYCLES disables the watchdog
    localparam logic [23:0] c_tmo_last = TIMEOUT_CYCLES - 24'd1;
    localparam logic        c_tmo_en   = (TIMEOUT_CYCLES != 24'd0);

    logic [1:0]              r_state;
    logic [23:0]             r_tcnt;
    logic                    r_force_mark;
    logic                    r_vsync_q;
    logic                    r_done;
    logic                    r_forced;
    logic [FCNT_W-1:0]       r_frame_cnt;
    logic [NUM_REGS*32-1:0]  r_active_cfg;

    logic                    w_rise;
    logic                    w_timeout;

    assign w_rise    = vsync_i & ~r_vsync_q;
    assign w_timeout = c_tmo_en && (r_tcnt == c_tmo_last);

    // Vsync edge history and frame counter, independent of commit state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vsync_q   <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_vsync_q <= vsync_i;
            if (w_rise) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    // Commit sequencer with registered active config, done and forced flags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= c_st_idle;
            r_tcnt       <= '0;
            r_force_mark <= 1'b0;
            r_done       <= 1'b0;
            r_forced     <= 1'b0;
            r_active_cfg <= '0;
        end else begin
            r_done <= 1'b0;
            // A forced apply in the same cycle overrides this clear below
            if (clr_forced_i) begin
                r_forced <= 1'b0;
            end

            case (r_state)
                c_st_idle: begin
                    r_force_mark <= 1'b0;
                    if (commit_req_i) begin
                        if (immediate_i) begin
                            r_state <= c_st_apply;
                        end else begin
                            r_state <= c_st_armed;
                            r_tcnt  <= '0;
                        end
                    end
                end

                c_st_armed: begin
                    // Further requests are absorbed: staging is sampled at
                    // apply time, so the newest staged data is what lands.
                    r_tcnt <= r_tcnt + 24'd1;
                    if (w_rise) begin
                        r_state      <= c_st_apply;
                        r_force_mark <= 1'b0;
                    end else if (w_timeout) begin
                        r_state      <= c_st_apply;
                        r_force_mark <= 1'b1;
                    end
                end

                c_st_apply: begin
                    r_active_cfg <= staged_cfg_i;
                    r_done       <= 1'b1;
                    r_force_mark <= 1'b0;
                    if (r_force_mark) begin
                        r_forced <= 1'b1;
                    end
                    // The apply state lasts one cycle, so a request seen
                    // here re-arms directly for the following frame.
                    if (commit_req_i) begin
                        r_state <= c_st_armed;
                        r_tcnt  <= '0;
                    end else begin
                        r_state <= c_st_idle;
                    end
                end

                default: begin
                    r_state      <= c_st_idle;
                    r_force_mark <= 1'b0;
                end
            endcase
        end
    end

    assign active_cfg_o = r_active_cfg;
    assign done_o       = r_done;
    assign forced_o     = r_forced;
    assign frame_cnt_o  = r_frame_cnt;
    assign busy_o       = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_sc_config_commit.sv
`default_nettype none
// ============================================================================
// Module      : tb_sc_config_commit
// Description : Scoreboard bench for sc_config_commit. A reference model
//               predicts each apply and queues the expected result; a monitor
//               compares whenever the design pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_config_commit;

    localparam int NUM_REGS = 13;
    localparam int W        = NUM_REGS * 32;
    localparam int FCNT_W   = 8;
    localparam int TMO      = 16;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [W-1:0]      staged_cfg_i = '0;
    logic              commit_req_i = 1'b0;
    logic              immediate_i  = 1'b0;
    logic              vsync_i      = 1'b0;
    logic              clr_forced_i = 1'b0;
    logic [W-1:0]      active_cfg_o;
    logic              busy_o;
    logic              done_o;
    logic              forced_o;
    logic [FCNT_W-1:0] frame_cnt_o;

    always #5 clk_i = ~clk_i;

    sc_config_commit #(
        .NUM_REGS       (NUM_REGS),
        .TIMEOUT_CYCLES (24'd16),
        .FCNT_W         (FCNT_W)
    ) u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .staged_cfg_i (staged_cfg_i),
        .commit_req_i (commit_req_i),
        .immediate_i  (immediate_i),
        .vsync_i      (vsync_i),
        .clr_forced_i (clr_forced_i),
        .active_cfg_o (active_cfg_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .forced_o     (forced_o),
        .frame_cnt_o  (frame_cnt_o)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] cfg;
        logic         forced;
    } exp_t;

    exp_t sb_q[$];

    task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: tracks whether a commit is waiting for a frame
    // boundary, how long it has waited, and whether an apply is due.
    bit           m_waiting     = 0;
    int           m_waited      = 0;
    bit           m_in_apply    = 0;
    bit           m_apply_force = 0;
    bit           m_prev_vs     = 0;
    bit           m_busy        = 0;
    bit           m_done        = 0;
    bit           m_forced      = 0;
    int unsigned  m_rises       = 0;
    logic [W-1:0] m_active      = '0;

    always @(posedge clk_i) begin : model
        bit rise;
        rise = vsync_i && !m_prev_vs;
        if (rst_i) begin
            m_waiting  = 0;
            m_waited   = 0;
            m_in_apply = 0;
            m_prev_vs  = 0;
            m_busy     = 0;
            m_done     = 0;
            m_forced   = 0;
            m_rises    = 0;
            m_active   = '0;
            sb_q.delete();
        end else begin
            m_prev_vs = vsync_i;
            if (rise) m_rises++;
            m_done = 0;
            if (clr_forced_i) m_forced = 0;
            if (m_in_apply) begin
                m_in_apply = 0;
                m_active   = staged_cfg_i;
                if (m_apply_force) m_forced = 1;
                m_done = 1;
                sb_q.push_back({staged_cfg_i, m_forced});
                if (commit_req_i) begin
                    m_waiting = 1;
                    m_waited  = 0;
                end
            end else if (m_waiting) begin
                m_waited++;
                if (rise) begin
                    m_waiting     = 0;
                    m_in_apply    = 1;
                    m_apply_force = 0;
                end else if (m_waited == TMO) begin
                    m_waiting     = 0;
                    m_in_apply    = 1;
                    m_apply_force = 1;
                end
            end else if (commit_req_i) begin
                if (immediate_i) begin
                    m_in_apply    = 1;
                    m_apply_force = 0;
                end else begin
                    m_waiting = 1;
                    m_waited  = 0;
                end
            end
            m_busy = m_waiting || m_in_apply;
        end
    end

    // Monitor: cycle-level output checks plus scoreboard pop on done
    always @(negedge clk_i) begin : monitor
        exp_t e;
        chk("busy", W'(busy_o), W'(m_busy));
        chk("done", W'(done_o), W'(m_done));
        chk("forced", W'(forced_o), W'(m_forced));
        chk("frame_cnt", W'(frame_cnt_o), W'(m_rises % (1 << FCNT_W)));
        chk("active_cfg", active_cfg_o, m_active);
        if (done_o) begin
            if (sb_q.size() == 0) begin
                chk("sb_spurious_done", W'(1), W'(0));
            end else begin
                e = sb_q.pop_front();
                chk("sb_cfg", active_cfg_o, e.cfg);
                chk("sb_forced", W'(forced_o), W'(e.forced));
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic req(bit imm);
        commit_req_i = 1'b1;
        immediate_i  = imm;
        cyc(1);
        commit_req_i = 1'b0;
        immediate_i  = 1'b0;
    endtask

    task automatic rand_staging();
        for (int k = 0; k < NUM_REGS; k++) staged_cfg_i[k*32 +: 32] = $urandom;
    endtask

    initial begin : stim
        logic [W-1:0] last;
        int           vs_timer;
        cyc(3);
        rst_i = 1'b0;

        // Vsync-aligned commit
        staged_cfg_i[31:0] = 32'h1234;
        req(1'b0);
        cyc(10);
        chk("p1_busy_armed", W'(busy_o), W'(1));
        chk("p1_active_zero", active_cfg_o, '0);
        vsync_i = 1'b1;
        cyc(3);
        chk("p1_word0", W'(active_cfg_o[31:0]), W'(32'h1234));
        chk("p1_busy_idle", W'(busy_o), W'(0));
        chk("p1_not_forced", W'(forced_o), W'(0));
        vsync_i = 1'b0;
        cyc(2);

        // Immediate commit
        staged_cfg_i[12*32 +: 32] = 32'hA5A5_0001;
        req(1'b1);
        cyc(1);
        chk("p2_word12", W'(active_cfg_o[12*32 +: 32]), W'(32'hA5A5_0001));

        // Watchdog-forced commit, then clear
        req(1'b0);
        cyc(20);
        chk("p3_forced_set", W'(forced_o), W'(1));
        clr_forced_i = 1'b1;
        cyc(1);
        clr_forced_i = 1'b0;
        chk("p3_forced_clr", W'(forced_o), W'(0));

        // Staging changes while armed; latest data wins
        req(1'b0);
        cyc(3);
        rand_staging();
        req(1'b0);
        rand_staging();
        last = staged_cfg_i;
        cyc(2);
        vsync_i = 1'b1;
        cyc(3);
        chk("p4_latest", active_cfg_o, last);
        vsync_i = 1'b0;
        cyc(2);

        // Request during the apply cycle re-arms
        commit_req_i = 1'b1;
        immediate_i  = 1'b1;
        cyc(1);
        immediate_i  = 1'b0;
        cyc(1);
        commit_req_i = 1'b0;
        chk("p5_rearmed", W'(busy_o), W'(1));
        rand_staging();
        last = staged_cfg_i;
        cyc(2);
        vsync_i = 1'b1;
        cyc(3);
        chk("p5_second", active_cfg_o, last);
        vsync_i = 1'b0;
        cyc(2);

        // Reset while armed, then frame counter wrap
        req(1'b0);
        vsync_i = 1'b1;
        cyc(1);
        vsync_i = 1'b0;
        rst_i = 1'b1;
        cyc(2);
        rst_i = 1'b0;
        cyc(1);
        chk("p6_active_rst", active_cfg_o, '0);
        chk("p6_fcnt_rst", W'(frame_cnt_o), W'(0));
        for (int i = 0; i < 256; i++) begin
            vsync_i = 1'b1;
            cyc(1);
            vsync_i = 1'b0;
            cyc(1);
        end
        chk("p6_fcnt_wrap", W'(frame_cnt_o), W'(0));

        // Randomised traffic
        vs_timer = 5;
        for (int i = 0; i < 3000; i++) begin
            commit_req_i = ($urandom % 10) == 0;
            immediate_i  = ($urandom % 3) == 0;
            clr_forced_i = ($urandom % 20) == 0;
            rst_i        = ($urandom % 600) == 0;
            if (($urandom % 4) == 0) staged_cfg_i[($urandom % NUM_REGS)*32 +: 32] = $urandom;
            if (vs_timer == 0) begin
                vsync_i  = ~vsync_i;
                vs_timer = $urandom_range(2, 30);
            end else begin
                vs_timer--;
            end
            cyc(1);
        end
        commit_req_i = 1'b0;
        immediate_i  = 1'b0;
        clr_forced_i = 1'b0;
        rst_i        = 1'b0;
        vsync_i      = 1'b0;
        cyc(40);
        chk("sb_drained", W'(sb_q.size()), W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
